// File: rtl/ifetch_prefetch_if.sv
// Fetch front-end bundle: imem request/response channel, execute redirect and decode handoff.
// master = fetch unit, slave = surrounding core/memory environment.
interface ifetch_prefetch_if;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  modport master (
    input  fetch_en, redirect_valid, redirect_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  if_ready,
    output imem_req_valid, imem_req_addr,
    output if_valid, if_instr, if_pc
  );

  modport slave (
    output fetch_en, redirect_valid, redirect_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output if_ready,
    input  imem_req_valid, imem_req_addr,
    input  if_valid, if_instr, if_pc
  );
endinterface

// File: rtl/ifetch_prefetch.sv
// RV32 fetch front end: PC, credit-limited imem requests, prefetch FIFO, redirect flush.
// Response -> if_* in one cycle when empty; requests stall on decode backpressure via FIFO credit.
module ifetch_prefetch #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_OUTST = 4,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input logic               clk,
  input logic               reset,
  ifetch_prefetch_if.master bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUTST);

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

  state_t        state;
  state_t        state_next;

  logic [31:0]   fetch_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] outst;
  logic [CW-1:0] outst_next;
  logic [CW-1:0] drop;
  logic [CW-1:0] drop_next;
  logic [CW:0]   credit_used;

  logic [31:0]   fifo_pc    [DEPTH];
  logic [31:0]   fifo_instr [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  logic [31:0]   pcq [DEPTH];
  logic [PW-1:0] pcq_rd;
  logic [PW-1:0] pcq_wr;

  logic          req_fire;
  logic          rsp;
  logic          push;
  logic          pop;

  // Every outstanding request already owns a FIFO slot, so responses never need stalling.
  assign credit_used = {1'b0, count} + {1'b0, outst};
  assign req_fire    = bus.imem_req_valid & bus.imem_req_ready;
  assign rsp         = bus.imem_rsp_valid;
  assign push        = rsp & (drop == '0) & ~bus.redirect_valid;
  assign pop         = bus.if_valid & bus.if_ready & ~bus.redirect_valid;

  assign bus.imem_req_addr = fetch_pc;
  assign bus.if_valid      = (count != '0);
  assign bus.if_instr      = fifo_instr[rd_ptr];
  assign bus.if_pc         = fifo_pc[rd_ptr];

  always_comb begin
    outst_next = outst;
    if (req_fire && !rsp)
      outst_next = outst + 1'b1;
    else if (!req_fire && rsp)
      outst_next = outst - 1'b1;
  end

  // A redirect cycle never issues, so outst_next is exactly what is still in flight.
  always_comb begin
    drop_next = drop;
    if (bus.redirect_valid)
      drop_next = outst_next;
    else if (rsp && drop != '0)
      drop_next = drop - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = FETCH;
      FETCH:   if (bus.redirect_valid && drop_next != '0) state_next = FLUSH;
      FLUSH:   if (drop_next == '0) state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.imem_req_valid = 1'b0;
    if (!reset && state != IDLE && bus.fetch_en && !bus.redirect_valid &&
        outst < MAX_C && credit_used < {1'b0, DEPTH_C})
      bus.imem_req_valid = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      outst    <= '0;
      drop     <= '0;
    end else begin
      outst <= outst_next;
      drop  <= drop_next;
      if (bus.redirect_valid)
        fetch_pc <= bus.redirect_pc & 32'hFFFF_FFFC;
      else if (req_fire)
        fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // The PC queue is never flushed: stale entries retire with their dropped responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcq_rd <= '0;
      pcq_wr <= '0;
      for (int i = 0; i < DEPTH; i++)
        pcq[i] <= '0;
    end else begin
      if (req_fire) begin
        pcq[pcq_wr] <= fetch_pc;
        pcq_wr      <= pcq_wr + 1'b1;
      end
      if (rsp)
        pcq_rd <= pcq_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc[i]    <= '0;
        fifo_instr[i] <= '0;
      end
    end else if (bus.redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_pc[wr_ptr]    <= pcq[pcq_rd];
        fifo_instr[wr_ptr] <= bus.imem_rsp_data;
        wr_ptr             <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  a_count_max:  assert property (@(posedge clk) disable iff (reset) count <= DEPTH_C);
  a_outst_max:  assert property (@(posedge clk) disable iff (reset) outst <= MAX_C);
  a_drop_outst: assert property (@(posedge clk) disable iff (reset) drop <= outst);
  a_credit:     assert property (@(posedge clk) disable iff (reset) credit_used <= {1'b0, DEPTH_C});
endmodule

// File: tb/tb_ifetch_prefetch.sv
// Bench for ifetch_prefetch: in-order variable-latency memory plus a sequential-PC stream model.
// Directed scenarios first, then randomized traffic with redirects and fetch_en gaps.
module tb_ifetch_prefetch;
  localparam int unsigned MAX_OUTST = 4;
  localparam logic [31:0] RESET_PC  = 32'h0;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } mreq_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  ifetch_prefetch_if bus();

  ifetch_prefetch #(.DEPTH(4), .MAX_OUTST(MAX_OUTST), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  mreq_t       memq[$];
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned last_due = 0;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;
  int unsigned ready_pct = 100;
  int unsigned req_cnt = 0;
  int unsigned dec_cnt = 0;
  logic [31:0] exp_req_pc;
  logic [31:0] exp_dec_pc;
  logic        prev_redir;
  logic        first_req_pending;
  logic [31:0] first_req_addr;
  logic        first_dec_pending;
  logic [31:0] first_dec_pc;
  logic        saw_fc;
  logic        saw_wrap;
  logic        obs_req_valid;
  logic [31:0] obs_req_addr;
  logic        obs_if_valid;
  logic [31:0] obs_if_pc;
  logic [31:0] obs_if_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {addr[15:0], addr[31:16]} ^ addr ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic model_init();
    exp_req_pc        = RESET_PC;
    exp_dec_pc        = RESET_PC;
    req_cnt           = 0;
    dec_cnt           = 0;
    prev_redir        = 1'b0;
    first_req_pending = 1'b0;
    first_dec_pending = 1'b0;
    first_req_addr    = '0;
    first_dec_pc      = '0;
    saw_fc            = 1'b0;
    saw_wrap          = 1'b0;
  endtask

  task automatic drive_mem();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    if (reset) begin
      memq.delete();
      last_due = 0;
    end else if (memq.size() != 0 && memq[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(memq[0].addr);
      void'(memq.pop_front());
    end
    bus.imem_req_ready = ($urandom_range(1, 100) <= ready_pct);
  endtask

  task automatic observe();
    mreq_t m;
    obs_req_valid = bus.imem_req_valid;
    obs_req_addr  = bus.imem_req_addr;
    obs_if_valid  = bus.if_valid;
    obs_if_pc     = bus.if_pc;
    obs_if_instr  = bus.if_instr;
    if (reset) begin
      prev_redir = 1'b0;
      return;
    end
    if (bus.redirect_valid) chk("req_during_redirect", 32'(bus.imem_req_valid), 32'd0);
    if (!bus.fetch_en)      chk("req_while_disabled", 32'(bus.imem_req_valid), 32'd0);
    if (prev_redir)         chk("valid_after_redirect", 32'(bus.if_valid), 32'd0);
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      chk("req_addr", bus.imem_req_addr, exp_req_pc);
      if (first_req_pending) begin
        first_req_addr    = bus.imem_req_addr;
        first_req_pending = 1'b0;
      end
      if (saw_fc && bus.imem_req_addr == 32'h0) saw_wrap = 1'b1;
      saw_fc     = (bus.imem_req_addr == 32'hFFFF_FFFC);
      exp_req_pc = exp_req_pc + 32'd4;
      m.addr     = bus.imem_req_addr;
      m.due      = cyc + $urandom_range(lat_min, lat_max);
      if (m.due <= last_due) m.due = last_due + 1;
      last_due = m.due;
      memq.push_back(m);
      req_cnt++;
      chk("outstanding_limit", 32'(memq.size() <= MAX_OUTST), 32'd1);
    end
    if (bus.redirect_valid) begin
      exp_req_pc        = bus.redirect_pc & 32'hFFFF_FFFC;
      exp_dec_pc        = bus.redirect_pc & 32'hFFFF_FFFC;
      first_req_pending = 1'b1;
      first_dec_pending = 1'b1;
    end else if (bus.if_valid && bus.if_ready) begin
      chk("dec_pc", bus.if_pc, exp_dec_pc);
      chk("dec_instr", bus.if_instr, mem_word(exp_dec_pc));
      if (first_dec_pending) begin
        first_dec_pc      = bus.if_pc;
        first_dec_pending = 1'b0;
      end
      exp_dec_pc = exp_dec_pc + 32'd4;
      dec_cnt++;
    end
    prev_redir = bus.redirect_valid;
  endtask

  task automatic step();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    cyc++;
    drive_mem();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    step();
    reset = 1'b0;
    model_init();
  endtask

  task automatic redirect_to(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    step();
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int unsigned n;
    logic found;
    bus.fetch_en       = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.if_ready       = 1'b1;
    model_init();
    @(posedge clk);
    #1;

    // Straight-line stream, 1-cycle memory, decode always ready.
    do_reset();
    step();
    chk("rst_if_valid", 32'(obs_if_valid), 32'd0);
    chk("rst_req_valid", 32'(obs_req_valid), 32'd0);
    chk("rst_if_pc", obs_if_pc, 32'd0);
    chk("rst_if_instr", obs_if_instr, 32'd0);
    step();
    chk("t1_first_req", 32'(obs_req_valid), 32'd1);
    chk("t1_first_addr", obs_req_addr, RESET_PC);
    step();
    chk("t1_empty_before_rsp", 32'(obs_if_valid), 32'd0);
    step();
    chk("t1_first_valid", 32'(obs_if_valid), 32'd1);
    chk("t1_first_pc", obs_if_pc, RESET_PC);
    n = dec_cnt;
    repeat (16) step();
    chk("t1_rate", dec_cnt - n, 32'd16);

    // Decode stalled: credit stops issue at DEPTH requests.
    bus.if_ready = 1'b0;
    do_reset();
    repeat (12) step();
    chk("t2_req_count", req_cnt, 32'd4);
    chk("t2_req_stopped", 32'(obs_req_valid), 32'd0);
    chk("t2_head_pc", obs_if_pc, 32'h0);
    bus.if_ready = 1'b1;
    repeat (12) step();
    chk("t2_resume", 32'(dec_cnt >= 6), 32'd1);

    // Three requests in flight when redirected.
    lat_min = 4;
    lat_max = 4;
    do_reset();
    repeat (4) step();
    chk("t3_inflight", req_cnt, 32'd3);
    chk("t3_no_rsp_yet", 32'(bus.imem_rsp_valid), 32'd0);
    redirect_to(32'h100);
    repeat (20) step();
    chk("t3_first_dec_seen", 32'(first_dec_pending), 32'd0);
    chk("t3_first_dec_pc", first_dec_pc, 32'h100);

    // Redirect coinciding with the last response and a pop on a loaded FIFO.
    lat_min = 2;
    lat_max = 2;
    bus.if_ready = 1'b0;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (bus.imem_rsp_valid && memq.size() == 0 && bus.if_valid) found = 1'b1;
    end
    chk("t4_setup_found", 32'(found), 32'd1);
    bus.if_ready = 1'b1;
    redirect_to(32'h340);
    step();
    chk("t4_empty_next", 32'(obs_if_valid), 32'd0);
    repeat (10) step();
    chk("t4_first_dec_pc", first_dec_pc, 32'h340);

    // Alignment of redirect target and 32-bit PC wrap.
    lat_min = 1;
    lat_max = 1;
    do_reset();
    repeat (3) step();
    redirect_to(32'h203);
    repeat (6) step();
    chk("t5_align_req", first_req_addr, 32'h200);
    chk("t5_align_dec", first_dec_pc, 32'h200);
    redirect_to(32'hFFFF_FFF4);
    repeat (12) step();
    chk("t5_wrap", 32'(saw_wrap), 32'd1);

    // Reset in the middle of traffic.
    lat_min = 2;
    lat_max = 2;
    bus.if_ready = 1'b0;
    do_reset();
    repeat (5) step();
    do_reset();
    step();
    chk("t6_if_valid", 32'(obs_if_valid), 32'd0);
    chk("t6_req_idle", 32'(obs_req_valid), 32'd0);
    step();
    chk("t6_req_valid", 32'(obs_req_valid), 32'd1);
    chk("t6_req_addr", obs_req_addr, RESET_PC);
    bus.if_ready = 1'b1;
    repeat (10) step();
    chk("t6_drained", 32'(dec_cnt > 0), 32'd1);

    // Randomized traffic: memory stalls, variable latency, redirects, fetch gaps.
    lat_min   = 1;
    lat_max   = 5;
    ready_pct = 75;
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      bus.fetch_en       = ($urandom_range(0, 9) != 0);
      bus.if_ready       = ($urandom_range(0, 2) != 0);
      bus.redirect_valid = ($urandom_range(0, 24) == 0);
      bus.redirect_pc    = $urandom;
      step();
    end
    bus.redirect_valid = 1'b0;
    chk("rand_progress", 32'(dec_cnt > 200), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
